// File: rtl/taylor_pkg.sv
// taylor_pkg: shared constants and FSM state type for the cosine request driver
package taylor_pkg;
  localparam int W = 24;
  localparam int FXP_SHIFT = 23;
  localparam int FXP_ONE = 8388608;
  localparam logic [W-1:0] HALF_PI_Q23 = 24'd13176795;
  localparam logic [W-1:0] NEG_THRESH = 24'hC00000;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_RELEASE,
    S_RESP
  } state_e;
endpackage

// File: rtl/cos_quadrant_fold.sv
// cos_quadrant_fold: folds a full-turn phase into quadrant 0 and sign-corrects the core result
//   phase_i  full-circle phase, 2^W = one turn
//   sign_o   1 when the cosine of phase_i is negative
//   r_o      folded residue, 0..2^(W-2)
//   sign_i   latched sign for the result being converted
//   result_i raw core output
//   cos_o    signed Q2.23 cosine
module cos_quadrant_fold
  import taylor_pkg::*;
#(
  parameter int WD = taylor_pkg::W
) (
  input  logic [WD-1:0] phase_i,
  output logic          sign_o,
  output logic [WD-2:0] r_o,
  input  logic          sign_i,
  input  logic [WD-1:0] result_i,
  output logic [WD:0]   cos_o
);
  localparam logic [WD-2:0] QV = {1'b1, {(WD-2){1'b0}}};
  localparam logic [WD-1:0] NEG = {2'b11, {(WD-2){1'b0}}};
  logic [WD-1:0] mag;
  assign sign_o = phase_i[WD-1] ^ phase_i[WD-2];
  // odd quadrants mirror the residue so the angle runs back down toward 0
  assign r_o = phase_i[WD-2] ? QV - {1'b0, phase_i[WD-3:0]} : {1'b0, phase_i[WD-3:0]};
  // series overshoot just past pi/2 comes back as a small negative number
  assign mag = (result_i >= NEG) ? '0 : result_i;
  assign cos_o = sign_i ? -{1'b0, mag} : {1'b0, mag};
endmodule

// File: rtl/cos_phase_driver.sv
// cos_phase_driver: runs the Taylor cosine core for one phase request at a time
//   req_*   phase request handshake (req_ready high only in IDLE)
//   core_*  start/angle to the core, ready/result back from it
//   resp_*  signed cosine response handshake, resp_err flags a core timeout
module cos_phase_driver
  import taylor_pkg::*;
#(
  parameter int WD = taylor_pkg::W,
  parameter int TIMEOUT = 16,
  parameter logic [WD-1:0] HALF_PI = taylor_pkg::HALF_PI_Q23
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [WD-1:0] req_phase,
  output logic          core_start,
  output logic [WD-1:0] core_angle,
  input  logic          core_ready,
  input  logic [WD-1:0] core_result,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [WD:0]   resp_cos,
  output logic          resp_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, err_q, err_d, f_sign;
  logic [WD-2:0] rp_q, rp_d, f_r;
  logic [WD-1:0] angle_q, angle_d;
  logic [WD:0] cos_q, cos_d, f_cos;
  logic [2*WD-2:0] prod;
  cos_quadrant_fold #(.WD(WD)) u_fold (
    .phase_i (req_phase),
    .sign_o  (f_sign),
    .r_o     (f_r),
    .sign_i  (sign_q),
    .result_i(core_result),
    .cos_o   (f_cos)
  );
  // r' spans 0..2^(W-2), so >> (W-2) scales it to 0..pi/2
  assign prod = {{WD{1'b0}}, rp_q} * {{(WD-1){1'b0}}, HALF_PI};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    rp_d = rp_q;
    angle_d = angle_q;
    cos_d = cos_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_PREP;
        sign_d = f_sign;
        rp_d = f_r;
      end
      S_PREP: begin
        angle_d = WD'(prod >> (WD - 2));
        state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_GUARD;
      // core_ready here may still be left over from the previous operation
      S_GUARD: begin
        cnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (core_ready) begin
        cos_d = f_cos;
        err_d = 1'b0;
        state_d = S_RELEASE;
      end else if (cnt_q == CW'(TIMEOUT)) begin
        cos_d = '0;
        err_d = 1'b1;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_RELEASE: state_d = S_RESP;
      S_RESP: state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sign_q <= 1'b0;
      rp_q <= '0;
      angle_q <= '0;
      cos_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
      rp_q <= rp_d;
      angle_q <= angle_d;
      cos_q <= cos_d;
      err_q <= err_d;
    end
  end
  // LAUNCH and RELEASE are never adjacent, so start is never high twice in a row
  assign core_start = (state_q == S_LAUNCH) || (state_q == S_RELEASE);
  assign req_ready = state_q == S_IDLE;
  assign resp_valid = state_q == S_RESP;
  assign core_angle = angle_q;
  assign resp_cos = cos_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_cos_phase_driver.sv
// tb_cos_phase_driver: directed checks of the cosine driver against a simple core model
module tb_cos_phase_driver;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic resp_ready = 1'b0;
  logic hang_mode = 1'b0;
  logic [23:0] req_phase = '0;
  logic [23:0] core_val = '0;
  logic req_ready, core_start, core_ready, resp_valid, resp_err;
  logic [23:0] core_angle;
  logic [24:0] resp_cos;
  logic busy = 1'b0;
  logic rdy = 1'b0;
  logic prev_start = 1'b0;
  logic dbl = 1'b0;
  int k = 0;
  int n_chk = 0;
  int n_pass = 0;

  cos_phase_driver dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_phase  (req_phase),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_ready (core_ready),
    .core_result(core_val),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_cos   (resp_cos),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;
  assign core_ready = rdy;

  // core model: ready falls one edge after launch, rises four edges later, stays high after release
  always @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      rdy <= 1'b0;
      k <= 0;
    end else if (!busy) begin
      if (core_start) begin
        busy <= 1'b1;
        k <= 0;
      end
    end else begin
      k <= k + 1;
      if (k == 0) rdy <= 1'b0;
      if (k == 4 && !hang_mode) rdy <= 1'b1;
      if (rdy && core_start) busy <= 1'b0;
    end
  end

  always @(negedge clock) begin
    if (core_start && prev_start) dbl <= 1'b1;
    prev_start <= core_start;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic run_op(input string tag, input logic [23:0] ph, input logic [23:0] cv,
                        input logic hang, input int exp_ang, input int exp_cos,
                        input logic exp_err, input int exp_lat, input int exp_starts,
                        input int hold);
    int lat;
    int starts;
    core_val = cv;
    hang_mode = hang;
    @(negedge clock);
    chk({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_phase = ph;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    starts = 0;
    @(negedge clock);
    while (!resp_valid && lat < 40) begin
      if (core_start) starts++;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".angle"}, core_angle, exp_ang);
    chk({tag, ".cos"}, $signed(resp_cos), exp_cos);
    chk({tag, ".err"}, resp_err, exp_err);
    chk({tag, ".starts"}, starts, exp_starts);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk({tag, ".hold_valid"}, resp_valid, 1);
      chk({tag, ".hold_req_ready"}, req_ready, 0);
      chk({tag, ".hold_start"}, core_start, 0);
      chk({tag, ".hold_cos"}, $signed(resp_cos), exp_cos);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.start", core_start, 0);
    chk("rst.angle", core_angle, 0);
    chk("rst.valid", resp_valid, 0);
    chk("rst.cos", resp_cos, 0);
    chk("rst.err", resp_err, 0);
    reset = 1'b0;
    run_op("ph000000", 24'h000000, 24'h800000, 1'b0, 0, 8388608, 1'b0, 9, 2, 0);
    run_op("ph800000", 24'h800000, 24'h800000, 1'b0, 0, -8388608, 1'b0, 9, 2, 0);
    run_op("ph400000", 24'h400000, 24'hFFFFF0, 1'b0, 13176795, 0, 1'b0, 9, 2, 0);
    run_op("ph200000", 24'h200000, 24'd5931642, 1'b0, 6588397, 5931642, 1'b0, 9, 2, 5);
    run_op("ph600000", 24'h600000, 24'd5931642, 1'b0, 6588397, -5931642, 1'b0, 9, 2, 0);
    run_op("ph100000", 24'h100000, 24'd7750063, 1'b0, 3294198, 7750063, 1'b0, 9, 2, 0);
    run_op("phC00000", 24'hC00000, 24'hC00000, 1'b0, 13176795, 0, 1'b0, 9, 2, 0);
    run_op("phE00000", 24'hE00000, 24'd5931642, 1'b0, 6588397, 5931642, 1'b0, 9, 2, 0);
    core_val = 24'd7750063;
    @(negedge clock);
    req_valid = 1'b1;
    req_phase = 24'h100000;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst.req_ready", req_ready, 1);
    chk("midrst.valid", resp_valid, 0);
    chk("midrst.angle", core_angle, 0);
    chk("midrst.cos", resp_cos, 0);
    chk("midrst.err", resp_err, 0);
    chk("midrst.start", core_start, 0);
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    chk("midrst.req_ignored", req_ready, 1);
    run_op("phA00000", 24'hA00000, 24'd5931642, 1'b0, 6588397, -5931642, 1'b0, 9, 2, 0);
    run_op("timeout", 24'h300000, 24'h800000, 1'b1, 9882596, 0, 1'b1, 20, 1, 0);
    @(negedge clock);
    chk("no_double_start", dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
